// File: rtl/wb_master_bridge.sv
// Wishbone classic-cycle initiator: one valid/ready command becomes one bus cycle and one response.
// Define WB_MASTER_TIMEOUT_EN to abort cycles that are not acked within TIMEOUT_CYCLES.
module wb_master_bridge #(
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ERR_CNT_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_we_i,
    input  logic [WB_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [WB_DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [WB_DATA_WIDTH-1:0]   rsp_data_o,
    output logic                       rsp_err_o,
    output logic [WB_DATA_WIDTH-1:0]   wb_data_o,
    input  logic [WB_DATA_WIDTH-1:0]   wb_data_i,
    output logic [WB_ADDR_WIDTH-1:0]   wb_addr_o,
    output logic                       wb_we_o,
    output logic                       wb_cyc_o,
    output logic [WB_DATA_WIDTH/8-1:0] wb_stb_o,
    input  logic                       wb_ack_i,
    output logic [ERR_CNT_WIDTH-1:0]   timeout_cnt_o
);

    localparam int unsigned SW = WB_DATA_WIDTH / 8;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid holds its payload stable until that edge, ready may change freely.
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     cmd_ready_d;
    logic                     rsp_valid_d;
    logic [WB_DATA_WIDTH-1:0] rsp_data_d;
    logic [WB_DATA_WIDTH-1:0] wb_data_d;
    logic [WB_ADDR_WIDTH-1:0] wb_addr_d;
    logic                     wb_we_d;
    logic                     wb_cyc_d;
    logic [SW-1:0]            wb_stb_d;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BUS_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]            bus_cnt_q, bus_cnt_d;
    logic                     rsp_err_d;
    logic [ERR_CNT_WIDTH-1:0] timeout_cnt_d;
`else
    assign rsp_err_o     = 1'b0;
    assign timeout_cnt_o = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_o;
        rsp_data_d  = rsp_data_o;
        wb_data_d   = wb_data_o;
        wb_addr_d   = wb_addr_o;
        wb_we_d     = wb_we_o;
        wb_cyc_d    = wb_cyc_o;
        wb_stb_d    = wb_stb_o;
`ifdef WB_MASTER_TIMEOUT_EN
        bus_cnt_d     = bus_cnt_q;
        rsp_err_d     = rsp_err_o;
        timeout_cnt_d = timeout_cnt_o;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    wb_we_d   = cmd_we_i;
                    wb_addr_d = cmd_addr_i;
                    wb_data_d = cmd_data_i;
                    wb_stb_d  = cmd_sel_i;
                    wb_cyc_d  = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    bus_cnt_d = '0;
`endif
                    state_d   = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wb_ack_i) begin
                    rsp_data_d  = wb_we_o ? '0 : wb_data_i;
                    rsp_valid_d = 1'b1;
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (bus_cnt_q == BUS_LAST) begin
                    rsp_data_d    = '1;
                    rsp_err_d     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    wb_cyc_d      = 1'b0;
                    wb_stb_d      = '0;
                    timeout_cnt_d = (timeout_cnt_o == '1) ? timeout_cnt_o : timeout_cnt_o + 1'b1;
                    state_d       = RESP;
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            wb_data_o   <= '0;
            wb_addr_o   <= '0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_o <= cmd_ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_data_o  <= rsp_data_d;
            wb_data_o   <= wb_data_d;
            wb_addr_o   <= wb_addr_d;
            wb_we_o     <= wb_we_d;
            wb_cyc_o    <= wb_cyc_d;
            wb_stb_o    <= wb_stb_d;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_cnt_q     <= '0;
            rsp_err_o     <= 1'b0;
            timeout_cnt_o <= '0;
        end else begin
            bus_cnt_q     <= bus_cnt_d;
            rsp_err_o     <= rsp_err_d;
            timeout_cnt_o <= timeout_cnt_d;
        end
    end
`endif

endmodule
